dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Parametrised successor data memory with load/store alignment unit for the RISC-V pipeline MEM stage.
- Owns a byte-writable RAM and a valid/ready request port with a registered response.
- Adds configurable word width (32/64), configurable read latency, and correct byte-lane extraction on loads at any offset.
- Adds LHU zero-extension, plus misalignment/illegal-op error reporting.

Parameters:
- DM_ADDRESS, 9, byte-address width; depth = 2**DM_ADDRESS / (DATA_W/8) words.
- DATA_W, 32, word width; legal values 32 or 64.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  instruction bits 14:12.
- req_addr  input  DM_ADDRESS  byte address (ALU result LSBs).
- req_wdata  input  DATA_W  store data (rs2).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  DATA_W  extended load result; 0 for stores and errors.
- rsp_err  output  1  misaligned or illegal access; qualified by rsp_valid.

Behaviour:
- Reset state: FSM in IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents are not reset.
- FSM states: IDLE, RD_WAIT, RESP. req_ready is high only in IDLE. Request fields are ignored unless req_valid && req_ready.
- Accept in IDLE (edge N):
  - Store or error: go to RESP; rsp_valid is high in cycle N+1.
  - Legal load: go to RD_WAIT; count down RD_LAT-1 cycles; go to RESP; rsp_valid is high in cycle N+RD_LAT.
- RESP always lasts exactly one cycle, then returns to IDLE. There is a one-cycle bubble between requests.
- Store write timing: the RAM byte-enable write commits on the accept edge.
- Store lanes: SB/SH/SW/SD shift req_wdata into lane addr[log2(DATA_W/8)-1:0]. Only the addressed bytes are enabled; other bytes are unchanged.
- Load lanes: select bytes at the address offset, then extend:
  - LB/LH/LW sign-extend.
  - LBU/LHU/LWU zero-extend.
  - LD (64-bit only) returns the full word.
- Misaligned access (no write, rsp_err=1, rsp_rdata=0):
  - H access with addr[0] != 0.
  - W access with addr[1:0] != 0.
  - D access with addr[2:0] != 0.
- Illegal access (no write, rsp_err=1, rsp_rdata=0):
  - When DATA_W=32: funct3 011 (LD/SD), or 110 (LWU).
  - Loads with funct3 111.
  - Stores with funct3 >= 100.
- Address wrap: none; the address is exactly DM_ADDRESS bits wide.
- Reset mid-operation: the FSM returns to IDLE and no rsp_valid is issued. A store already committed on its accept edge stays written. An in-flight load is discarded.
- Read path: the RAM read port is addressed by the captured word address; only the captured funct3/offset drive extraction.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- With the macro defined, three extra outputs exist: perf_loads, perf_stores, perf_errs, each 32 bits.
  - Each increments at the accept edge of its request class.
  - Each wraps at 2**32 and clears on reset.
- Without the macro, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams (F3_B/H/W/D/BU/HU/WU);
  - FSM state enum;
  - functions size_of(funct3), is_misaligned(funct3, offset), lane_extend(word, offset, funct3).
- Sub-module dmem_ram_be: byte-enable synchronous RAM, DEPTH x DATA_W, with an RD_LAT-stage read pipeline.

Test Plan:
- Store/load word, default params: SW 0xDEADBEEF @0x010, then LW @0x010 → rsp_valid 1 cycle after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte lanes, default params: after the word store above, SB 0x80 @0x013 → LB @0x013 returns 0xFFFFFF80; LBU @0x013 returns 0x00000080; LW @0x010 returns 0x80ADBEEF.
- Half extension, default params: SH 0x8001 @0x022 → LH returns 0xFFFF8001; LHU returns 0x00008001.
- Misaligned store, default params: SW @0x011 → rsp_err=1, rsp_rdata=0, and a later LW @0x010 shows the RAM unchanged.
- Latency and illegal op, RD_LAT=3, DATA_W=64:
  - SD 0x0123456789ABCDEF @0x008, then LD @0x008 → rsp_valid exactly 3 cycles after accept with the full value.
  - LWU @0x00C → 0x0000000001234567.
  - funct3 111 load → rsp_err=1.
- Reset mid-op, RD_LAT=4: accept LW, assert reset in cycle 2 → no rsp_valid; req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM states and the size / alignment / lane-extraction helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } dmem_state_t;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] offset);
    case (funct3[1:0])
      2'd1:    return offset[0] != 1'b0;
      2'd2:    return offset[1:0] != 2'b00;
      2'd3:    return offset != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // Works on a 64-bit view; 32-bit callers zero-pad the word and truncate the result.
  function automatic logic [63:0] lane_extend(input logic [63:0] word, input logic [2:0] offset,
                                              input logic [2:0] funct3);
    logic [63:0] sh;
    sh = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    return {{56{sh[7]}}, sh[7:0]};
      F3_H:    return {{48{sh[15]}}, sh[15:0]};
      F3_W:    return {{32{sh[31]}}, sh[31:0]};
      F3_BU:   return {56'd0, sh[7:0]};
      F3_HU:   return {48'd0, sh[15:0]};
      F3_WU:   return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response port of the data-memory load/store unit.
interface dmem_lsu_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram_be.sv
// Byte-enable synchronous RAM with an RD_LAT-stage registered read pipeline.
module dmem_ram_be #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe[0] <= mem[raddr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign rdata = pipe[RD_LAT-1];

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with load/store alignment for the pipeline MEM stage.
// Define DMEM_PERF_CNT_EN to add the perf_loads/perf_stores/perf_errs counters.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// RD_WAIT | legal load in flight, counting down the RAM read latency
// RESP    | one-cycle response pulse, then back to IDLE
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1
) (
  input logic       clk,
  input logic       reset,
  dmem_lsu_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
`endif
);
  localparam int NB    = DATA_W / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int WAW   = DM_ADDRESS - OFFW;
  localparam int DEPTH = 2 ** WAW;
  localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  dmem_state_t       state;
  logic [1:0]        cnt;
  logic [2:0]        cap_off;
  logic [2:0]        cap_f3;
  logic [WAW-1:0]    cap_waddr;
  logic              rsp_load;

  logic [OFFW-1:0]   req_off;
  logic [2:0]        off3;
  logic [WAW-1:0]    req_waddr;
  logic              accept, illegal, err, load_go, store_go;
  logic [7:0]        be_base;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [WAW-1:0]    ram_raddr;

  assign req_off   = bus.req_addr[OFFW-1:0];
  assign off3      = 3'(req_off);
  assign req_waddr = bus.req_addr[DM_ADDRESS-1:OFFW];
  assign accept    = bus.req_valid && bus.req_ready;

  always_comb begin
    illegal = 1'b0;
    if (DATA_W == 32 && (bus.req_funct3 == F3_D || bus.req_funct3 == F3_WU)) illegal = 1'b1;
    if (!bus.req_we && bus.req_funct3 == 3'b111) illegal = 1'b1;
    if (bus.req_we && bus.req_funct3[2]) illegal = 1'b1;
  end

  assign err      = illegal || is_misaligned(bus.req_funct3, off3);
  assign load_go  = accept && !bus.req_we && !err;
  assign store_go = accept && bus.req_we && !err;

  always_comb begin
    case (size_of(bus.req_funct3))
      2'd0:    be_base = 8'h01;
      2'd1:    be_base = 8'h03;
      2'd2:    be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
  end

  assign ram_be    = NB'(be_base) << req_off;
  assign ram_wdata = bus.req_wdata << {req_off, 3'b000};
  // The first read stage must launch on the accept edge, before the capture registers load.
  assign ram_raddr = (state == IDLE) ? req_waddr : cap_waddr;

  dmem_ram_be #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT),
    .AW     (WAW)
  ) u_ram (
    .clk   (clk),
    .we    (store_go),
    .be    (ram_be),
    .waddr (req_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      cap_off       <= 3'd0;
      cap_f3        <= 3'd0;
      cap_waddr     <= '0;
      rsp_load      <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_off       <= off3;
            cap_f3        <= bus.req_funct3;
            cap_waddr     <= req_waddr;
            bus.req_ready <= 1'b0;
            if (load_go && RD_LAT > 1) begin
              state <= RD_WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= err;
              rsp_load      <= load_go;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == 2'd0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            rsp_load      <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          rsp_load      <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rsp_rdata = rsp_load ? DATA_W'(lane_extend(64'(ram_rdata), cap_off, cap_f3)) : '0;

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads  <= 32'd0;
      perf_stores <= 32'd0;
      perf_errs   <= 32'd0;
    end else begin
      if (load_go)        perf_loads  <= perf_loads + 32'd1;
      if (store_go)       perf_stores <= perf_stores + 32'd1;
      if (accept && err)  perf_errs   <= perf_errs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: three instances (32b/lat1, 64b/lat3, 32b/lat4).
module tb_dmem_lsu;
  import dmem_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) if0 ();
  dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(64)) if1 ();
  dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) if2 ();

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] pl0, ps0, pe0, pl1, ps1, pe1, pl2, ps2, pe2;
`endif

  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(1)) u0 (
    .clk(clk), .reset(reset_a), .bus(if0)
`ifdef DMEM_PERF_CNT_EN
    , .perf_loads(pl0), .perf_stores(ps0), .perf_errs(pe0)
`endif
  );
  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(64), .RD_LAT(3)) u1 (
    .clk(clk), .reset(reset_a), .bus(if1)
`ifdef DMEM_PERF_CNT_EN
    , .perf_loads(pl1), .perf_stores(ps1), .perf_errs(pe1)
`endif
  );
  dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(4)) u2 (
    .clk(clk), .reset(reset_b), .bus(if2)
`ifdef DMEM_PERF_CNT_EN
    , .perf_loads(pl2), .perf_stores(ps2), .perf_errs(pe2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string dut, input exp_t e, input logic [63:0] data, input logic err);
    checks++;
    if (data !== e.data || err !== e.err || cyc !== e.cyc) begin
      errors++;
      $display("FAIL %s %s: got data=%h err=%b cyc=%0d expected data=%h err=%b cyc=%0d",
               dut, e.name, data, err, cyc, e.data, e.err, e.cyc);
    end
  endtask

  task automatic unexpected(input string dut);
    checks++;
    errors++;
    $display("FAIL %s unexpected_rsp at cyc=%0d: got rsp_valid=1 expected none", dut, cyc);
  endtask

  always @(negedge clk) begin
    if (if0.rsp_valid === 1'b1) begin
      if (q0.size() == 0) unexpected("dut0");
      else compare("dut0", q0.pop_front(), 64'(if0.rsp_rdata), if0.rsp_err);
    end
    if (if1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) unexpected("dut1");
      else compare("dut1", q1.pop_front(), if1.rsp_rdata, if1.rsp_err);
    end
    if (if2.rsp_valid === 1'b1) begin
      if (q2.size() == 0) unexpected("dut2");
      else compare("dut2", q2.pop_front(), 64'(if2.rsp_rdata), if2.rsp_err);
    end
  end

  task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [63:0] wdata);
    case (d)
      0: begin
        if0.req_valid = v; if0.req_we = we; if0.req_funct3 = f3;
        if0.req_addr = addr; if0.req_wdata = wdata[31:0];
      end
      1: begin
        if1.req_valid = v; if1.req_we = we; if1.req_funct3 = f3;
        if1.req_addr = addr; if1.req_wdata = wdata;
      end
      default: begin
        if2.req_valid = v; if2.req_we = we; if2.req_funct3 = f3;
        if2.req_addr = addr; if2.req_wdata = wdata[31:0];
      end
    endcase
  endtask

  function automatic logic ready_of(input int d);
    case (d)
      0:       return if0.req_ready;
      1:       return if1.req_ready;
      default: return if2.req_ready;
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Returns after the request is accepted (1 ns past the accept edge) or the wait expires.
  task automatic send(input int d, input logic we, input logic [2:0] f3, input logic [8:0] addr,
                      input logic [63:0] wdata, input string name, output bit ok);
    int waited = 0;
    @(negedge clk);
    drive(d, 1'b1, we, f3, addr, wdata);
    while (ready_of(d) !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = (ready_of(d) === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout: got req_ready=0 expected 1 within 20 cycles", name);
      drive(d, 1'b0, 1'b0, 3'd0, 9'd0, 64'd0);
      return;
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 1'b0, 3'd0, 9'd0, 64'd0);
  endtask

  task automatic issue(input int d, input logic we, input logic [2:0] f3, input logic [8:0] addr,
                       input logic [63:0] wdata, input logic [63:0] exp_data, input logic exp_err,
                       input string name);
    exp_t e;
    bit   ok;
    int   lat;
    int   waited = 0;
    lat = (we || exp_err) ? 1 : (d == 1) ? 3 : (d == 2) ? 4 : 1;
    send(d, we, f3, addr, wdata, name, ok);
    if (!ok) return;
    e.data = exp_data;
    e.err  = exp_err;
    e.cyc  = cyc + lat - 1;
    e.name = name;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    while (qsize(d) != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (qsize(d) != 0) begin
      checks++;
      errors++;
      $display("FAIL %s rsp_timeout: got no rsp_valid expected one within 20 cycles", name);
      case (d)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end
  endtask

  initial begin
    bit ok;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 3'd0, 9'd0, 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_ready0", 64'(if0.req_ready), 64'd1);
    chk("rst_valid0", 64'(if0.rsp_valid), 64'd0);
    chk("rst_rdata0", 64'(if0.rsp_rdata), 64'd0);
    chk("rst_err0",   64'(if0.rsp_err),   64'd0);
    chk("rst_ready1", 64'(if1.req_ready), 64'd1);
    chk("rst_valid1", 64'(if1.rsp_valid), 64'd0);
    chk("rst_ready2", 64'(if2.req_ready), 64'd1);
    chk("rst_valid2", 64'(if2.rsp_valid), 64'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;

    // 32-bit, RD_LAT=1
    issue(0, 1'b1, F3_W,   9'h010, 64'hDEADBEEF, 64'h0, 1'b0, "sw_010");
    issue(0, 1'b0, F3_W,   9'h010, 64'h0, 64'hDEADBEEF, 1'b0, "lw_010");
    issue(0, 1'b1, F3_B,   9'h013, 64'h80, 64'h0, 1'b0, "sb_013");
    issue(0, 1'b0, F3_B,   9'h013, 64'h0, 64'hFFFFFF80, 1'b0, "lb_013");
    issue(0, 1'b0, F3_BU,  9'h013, 64'h0, 64'h00000080, 1'b0, "lbu_013");
    issue(0, 1'b0, F3_W,   9'h010, 64'h0, 64'h80ADBEEF, 1'b0, "lw_010_after_sb");
    issue(0, 1'b0, F3_B,   9'h010, 64'h0, 64'hFFFFFFEF, 1'b0, "lb_010");
    issue(0, 1'b0, F3_H,   9'h012, 64'h0, 64'hFFFF80AD, 1'b0, "lh_012");
    issue(0, 1'b1, F3_H,   9'h022, 64'h8001, 64'h0, 1'b0, "sh_022");
    issue(0, 1'b0, F3_H,   9'h022, 64'h0, 64'hFFFF8001, 1'b0, "lh_022");
    issue(0, 1'b0, F3_HU,  9'h022, 64'h0, 64'h00008001, 1'b0, "lhu_022");
    issue(0, 1'b1, F3_W,   9'h011, 64'h12345678, 64'h0, 1'b1, "sw_011_misaligned");
    issue(0, 1'b0, F3_W,   9'h010, 64'h0, 64'h80ADBEEF, 1'b0, "lw_010_unchanged");
    issue(0, 1'b0, F3_H,   9'h021, 64'h0, 64'h0, 1'b1, "lh_021_misaligned");
    issue(0, 1'b1, F3_D,   9'h010, 64'h55, 64'h0, 1'b1, "sd_illegal32");
    issue(0, 1'b0, F3_WU,  9'h010, 64'h0, 64'h0, 1'b1, "lwu_illegal32");
    issue(0, 1'b1, F3_BU,  9'h010, 64'h55, 64'h0, 1'b1, "store_f3_100");
    issue(0, 1'b0, F3_W,   9'h010, 64'h0, 64'h80ADBEEF, 1'b0, "lw_010_final");

    // 64-bit, RD_LAT=3
    issue(1, 1'b1, F3_D,   9'h008, 64'h0123456789ABCDEF, 64'h0, 1'b0, "sd_008");
    issue(1, 1'b0, F3_D,   9'h008, 64'h0, 64'h0123456789ABCDEF, 1'b0, "ld_008");
    issue(1, 1'b0, F3_WU,  9'h00C, 64'h0, 64'h0000000001234567, 1'b0, "lwu_00c");
    issue(1, 1'b0, F3_W,   9'h008, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, "lw_008");
    issue(1, 1'b0, F3_B,   9'h00B, 64'h0, 64'hFFFFFFFFFFFFFF89, 1'b0, "lb_00b");
    issue(1, 1'b0, F3_BU,  9'h00F, 64'h0, 64'h0000000000000001, 1'b0, "lbu_00f");
    issue(1, 1'b0, 3'b111, 9'h008, 64'h0, 64'h0, 1'b1, "load_f3_111");
    issue(1, 1'b0, F3_D,   9'h004, 64'h0, 64'h0, 1'b1, "ld_004_misaligned");
    issue(1, 1'b1, F3_W,   9'h00C, 64'hCAFEF00D, 64'h0, 1'b0, "sw_00c");
    issue(1, 1'b0, F3_D,   9'h008, 64'h0, 64'hCAFEF00D89ABCDEF, 1'b0, "ld_008_after_sw");

    // 32-bit, RD_LAT=4, then reset during an in-flight load
    issue(2, 1'b1, F3_W,   9'h040, 64'h11223344, 64'h0, 1'b0, "sw_040");
    issue(2, 1'b0, F3_W,   9'h040, 64'h0, 64'h11223344, 1'b0, "lw_040_lat4");
    send(2, 1'b0, F3_W, 9'h040, 64'h0, "lw_040_reset", ok);
    @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    chk("ready_after_reset", 64'(if2.req_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("no_rsp_after_reset", 64'(if2.rsp_valid), 64'd0);
      @(negedge clk);
    end
    issue(2, 1'b0, F3_W,   9'h040, 64'h0, 64'h11223344, 1'b0, "lw_040_post_reset");

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
